strap_seq_ctrl: RTL
===================

# strap_seq_ctrl

Parametrised strap and reset-sequencing controller for the pinmux block. After external reset it samples the pad straps through a stability filter, latches them, loads the software-visible sticky strap register, and sequences clock enable and soft reset release with programmable delays. It also services a software soft-reboot request by re-running the clock/soft-reset sequence while keeping the sticky configuration.

## Interface
- STRAP_W, 16: pad strap width; bit STRAP_W-1 is strap mode (1 = use DEFAULT_STRAP)
- STICKY_W, 32: sticky register width; multiple of 8, > STRAP_W
- DEFAULT_STRAP, 'h0 (STRAP_W-1 bits): strap value used when strap mode = 1
- FILT_DEPTH, 4: consecutive identical samples required to accept straps (>= 2)
- FILT_MAX, 64: filter timeout in cycles (> FILT_DEPTH)
- CLK_ENB_DLY, 8: cycles from p_reset_n release to clk_enb assertion (>= 1)
- SRST_DLY, 8: cycles from clk_enb assertion to s_reset_n release (>= 1)
- REBOOT_BIT, STICKY_W-1: sticky bit index of the soft-reboot request

- clk  input  1  system clock
- e_reset_n  input  1  external reset, asynchronous, active-low
- p_reset_n  input  1  power-on reset, active-low, synchronous to clk
- pad_strap_in  input  STRAP_W  raw strap pads
- cs  input  1  register select
- we  input  STICKY_W/8  byte write enables
- data_in  input  STICKY_W  write data
- strap_latch  output  STRAP_W  filtered latched strap
- strap_sticky  output  STICKY_W  software strap register
- strap_valid  output  1  strap_latch/strap_sticky valid
- strap_err  output  1  filter timed out; last sample used
- clk_enb  output  1  downstream clock enable
- s_reset_n  output  1  generated soft reset, active-low

## Operation
- Clocking: single clock clk; e_reset_n is asynchronous assert, active-low; all other inputs are sampled on posedge clk.
- States: FILT, LOAD, WAIT_POR, CLK_WAIT, SRST_WAIT, RUN, REBOOT. Reset state is FILT.
- All outputs reset to 0 (strap_latch, strap_sticky, strap_valid, strap_err, clk_enb, s_reset_n); filter counters reset to 0.
- FILT: each cycle, compare pad_strap_in with the previous sample. Equal increments stable_cnt; otherwise stable_cnt = 1. The first cycle gives stable_cnt = 1. A free-running timeout counter also runs.
  - stable_cnt == FILT_DEPTH: go to LOAD with the current sample.
  - Timeout counter == FILT_MAX: go to LOAD with the current sample and set strap_err = 1.
- LOAD, 1 cycle:
  - strap_latch <= filtered sample.
  - pstrap_select = strap_latch[STRAP_W-1] ? DEFAULT_STRAP : strap_latch[STRAP_W-2:0], using the new sample.
  - strap_sticky <= zero-extended pstrap_select, with REBOOT_BIT = 0.
  - strap_valid <= 1.
  - Go to WAIT_POR.
- WAIT_POR: clk_enb = 0, s_reset_n = 0, strap_sticky is reloaded from pstrap_select every cycle. Leave when p_reset_n = 1, going to CLK_WAIT.
- CLK_WAIT: count CLK_ENB_DLY cycles, then set clk_enb = 1 and go to SRST_WAIT.
- SRST_WAIT: count SRST_DLY cycles, then set s_reset_n = 1 and go to RUN.
- RUN: byte writes apply (cs && we[i] writes strap_sticky[8i+7:8i]). If the written value has REBOOT_BIT = 1, go to REBOOT next cycle.
- REBOOT, 1 cycle: clk_enb = 0, s_reset_n = 0, strap_sticky[REBOOT_BIT] cleared, all other sticky bits kept. Then go to CLK_WAIT.
- p_reset_n = 0 in any state after LOAD forces WAIT_POR next cycle: clk_enb and s_reset_n drop at once and strap_sticky is reloaded. strap_latch and strap_valid hold.
- Writes in any state other than RUN are ignored.
- If a write and p_reset_n = 0 occur in the same cycle, the reload wins.
- e_reset_n assertion mid-operation asynchronously clears everything and restarts at FILT.

## Timing
- Stable pads: from e_reset_n rise, LOAD occurs in cycle FILT_DEPTH+1 and strap_valid is high from cycle FILT_DEPTH+2.
- p_reset_n high sampled at edge N: clk_enb high after edge N+CLK_ENB_DLY; s_reset_n high after edge N+CLK_ENB_DLY+SRST_DLY.
- Reboot write at edge W:
  - Sticky bit reads 1 after edge W.
  - clk_enb/s_reset_n low and sticky bit cleared after edge W+1.
  - clk_enb high after edge W+1+CLK_ENB_DLY.
  - s_reset_n high after edge W+1+CLK_ENB_DLY+SRST_DLY.
- clk_enb and s_reset_n are registered and glitch-free. s_reset_n never releases while clk_enb = 0.

## Test plan
- Stable pads 'h0A35, p_reset_n already 1:
  - strap_latch = 'h0A35 at cycle 6.
  - strap_sticky = 'h0000_0A35.
  - clk_enb rises 8 cycles later, s_reset_n 16 cycles later; strap_err = 0.
- Pads toggle 'h0001/'h0002 every cycle for 80 cycles:
  - strap_err = 1 at cycle 64.
  - strap_latch equals the sample from cycle 64.
- Pads 'h8123 with DEFAULT_STRAP = 'h2560:
  - strap_latch = 'h8123.
  - strap_sticky = 'h0000_2560.
- In RUN, write 'h8000_00FF with we = 4'b1001:
  - strap_sticky[7:0] = 'hFF and the reboot bit pulses.
  - clk_enb/s_reset_n drop for one REBOOT cycle plus the delays.
  - Final strap_sticky = 'h0000_0AFF (for initial 'h0A35).
- p_reset_n pulsed low for 3 cycles in RUN, after a write of 'h0000_1234:
  - strap_sticky reloads to the strap map.
  - clk_enb/s_reset_n low the next cycle, then the full sequence re-runs.
- e_reset_n asserted during CLK_WAIT: all outputs go to 0 immediately and filtering restarts.

Source files
------------

// File: rtl/strap_seq_ctrl.sv
// strap_seq_ctrl
//   Strap filter and reset sequencer for the pinmux block. After external
//   reset the pad straps are filtered until stable (or a timeout expires),
//   latched, mapped into the software-visible sticky register, and then the
//   downstream clock enable and soft reset are released with programmable
//   delays. A software write setting REBOOT_BIT re-runs the clock/soft-reset
//   sequence while keeping the sticky contents.
//
// Ports
//   clk           system clock
//   e_reset_n     external reset, asynchronous, active-low
//   p_reset_n     power-on reset, active-low, synchronous to clk
//   pad_strap_in  raw strap pads (MSB = strap mode, 1 selects DEFAULT_STRAP)
//   cs            register select
//   we            byte write enables for strap_sticky
//   data_in       write data for strap_sticky
//   strap_latch   filtered latched strap
//   strap_sticky  software strap register
//   strap_valid   strap_latch / strap_sticky valid
//   strap_err     filter timed out, last sample used
//   clk_enb       downstream clock enable (registered)
//   s_reset_n     generated soft reset, active-low (registered)
module strap_seq_ctrl #(
    parameter int               STRAP_W       = 16,
    parameter int               STICKY_W      = 32,
    parameter logic [STRAP_W-2:0] DEFAULT_STRAP = '0,
    parameter int               FILT_DEPTH    = 4,
    parameter int               FILT_MAX      = 64,
    parameter int               CLK_ENB_DLY   = 8,
    parameter int               SRST_DLY      = 8,
    parameter int               REBOOT_BIT    = STICKY_W-1
) (
    input  logic                  clk,
    input  logic                  e_reset_n,
    input  logic                  p_reset_n,
    input  logic [STRAP_W-1:0]    pad_strap_in,
    input  logic                  cs,
    input  logic [STICKY_W/8-1:0] we,
    input  logic [STICKY_W-1:0]   data_in,
    output logic [STRAP_W-1:0]    strap_latch,
    output logic [STICKY_W-1:0]   strap_sticky,
    output logic                  strap_valid,
    output logic                  strap_err,
    output logic                  clk_enb,
    output logic                  s_reset_n
);

    // Filter counters must hold FILT_MAX+1 without wrapping.
    localparam int FCNT_W  = $clog2(FILT_MAX + 2);
    localparam int DLY_MAX = (CLK_ENB_DLY > SRST_DLY) ? CLK_ENB_DLY : SRST_DLY;
    localparam int DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX + 1) : 1;

    typedef enum logic [2:0] {
        S_FILT,
        S_LOAD,
        S_WAIT_POR,
        S_CLK_WAIT,
        S_SRST_WAIT,
        S_RUN,
        S_REBOOT
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [STRAP_W-1:0]   r_sample;
    logic [STRAP_W-1:0]   r_latch, w_latch_nxt;
    logic [FCNT_W-1:0]    r_stable_cnt, r_tmo_cnt;
    logic [DLY_W-1:0]     r_dly;
    logic [STICKY_W-1:0]  r_sticky, w_sticky_nxt, w_sticky_wr, w_strap_map;
    logic                 r_valid, w_valid_nxt;
    logic                 r_err, w_err_nxt;
    logic                 r_clk_enb, w_clk_enb_nxt;
    logic                 r_srst_n, w_srst_n_nxt;
    logic                 w_stable_hit, w_tmo_hit, w_por_abort, w_reboot_req;
    logic                 w_clk_dly_hit, w_srst_dly_hit;
    logic [STRAP_W-1:0]   w_map_src;
    logic [STRAP_W-2:0]   w_pstrap;

    assign w_stable_hit   = (r_stable_cnt == FCNT_W'(FILT_DEPTH));
    assign w_tmo_hit      = (r_tmo_cnt == FCNT_W'(FILT_MAX));
    assign w_clk_dly_hit  = (r_dly == DLY_W'(CLK_ENB_DLY - 1));
    assign w_srst_dly_hit = (r_dly == DLY_W'(SRST_DLY - 1));
    // Power-on reset only takes over once the straps have been loaded.
    assign w_por_abort    = !p_reset_n && (r_state != S_FILT) && (r_state != S_LOAD);

    // Strap map: in LOAD the freshly filtered sample is used, otherwise the latch.
    always_comb begin
        w_map_src   = (r_state == S_LOAD) ? r_sample : r_latch;
        w_pstrap    = w_map_src[STRAP_W-1] ? DEFAULT_STRAP : w_map_src[STRAP_W-2:0];
        w_strap_map = STICKY_W'(w_pstrap);
        w_strap_map[REBOOT_BIT] = 1'b0;
    end

    always_comb begin
        w_sticky_wr = r_sticky;
        for (int unsigned i = 0; i < STICKY_W/8; i++) begin
            if (cs && we[i]) begin
                w_sticky_wr[8*i +: 8] = data_in[8*i +: 8];
            end
        end
        w_reboot_req = cs && we[REBOOT_BIT/8] && data_in[REBOOT_BIT];
    end

    // State register
    always_ff @(posedge clk or negedge e_reset_n) begin
        if (!e_reset_n) begin
            r_state <= S_FILT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILT:      if (w_stable_hit || w_tmo_hit) w_state_nxt = S_LOAD;
            S_LOAD:      w_state_nxt = S_WAIT_POR;
            S_WAIT_POR:  if (p_reset_n) w_state_nxt = S_CLK_WAIT;
            S_CLK_WAIT:  if (w_clk_dly_hit) w_state_nxt = S_SRST_WAIT;
            S_SRST_WAIT: if (w_srst_dly_hit) w_state_nxt = S_RUN;
            S_RUN:       if (w_reboot_req) w_state_nxt = S_REBOOT;
            S_REBOOT:    w_state_nxt = S_CLK_WAIT;
            default:     w_state_nxt = S_FILT;
        endcase
        if (w_por_abort) begin
            w_state_nxt = S_WAIT_POR;
        end
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        w_latch_nxt   = r_latch;
        w_sticky_nxt  = r_sticky;
        w_valid_nxt   = r_valid;
        w_err_nxt     = r_err;
        w_clk_enb_nxt = r_clk_enb;
        w_srst_n_nxt  = r_srst_n;
        case (r_state)
            S_FILT: begin
                if (w_tmo_hit && !w_stable_hit) w_err_nxt = 1'b1;
            end
            S_LOAD: begin
                w_latch_nxt  = r_sample;
                w_sticky_nxt = w_strap_map;
                w_valid_nxt  = 1'b1;
            end
            S_WAIT_POR: begin
                w_clk_enb_nxt = 1'b0;
                w_srst_n_nxt  = 1'b0;
                w_sticky_nxt  = w_strap_map;
            end
            S_CLK_WAIT: begin
                if (w_clk_dly_hit) w_clk_enb_nxt = 1'b1;
            end
            S_SRST_WAIT: begin
                if (w_srst_dly_hit) w_srst_n_nxt = 1'b1;
            end
            S_RUN: begin
                w_sticky_nxt = w_sticky_wr;
            end
            S_REBOOT: begin
                w_clk_enb_nxt = 1'b0;
                w_srst_n_nxt  = 1'b0;
                w_sticky_nxt[REBOOT_BIT] = 1'b0;
            end
            default: ;
        endcase
        // Reload has priority over a same-cycle write.
        if (w_por_abort) begin
            w_clk_enb_nxt = 1'b0;
            w_srst_n_nxt  = 1'b0;
            w_sticky_nxt  = w_strap_map;
        end
    end

    // Datapath registers: filter, delay counter, outputs
    always_ff @(posedge clk or negedge e_reset_n) begin
        if (!e_reset_n) begin
            r_sample     <= '0;
            r_stable_cnt <= '0;
            r_tmo_cnt    <= '0;
            r_dly        <= '0;
            r_latch      <= '0;
            r_sticky     <= '0;
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
            r_clk_enb    <= 1'b0;
            r_srst_n     <= 1'b0;
        end else begin
            if (r_state == S_FILT) begin
                r_sample  <= pad_strap_in;
                r_tmo_cnt <= r_tmo_cnt + FCNT_W'(1);
                // A zero count marks the very first sample after reset.
                if ((r_stable_cnt == '0) || (pad_strap_in == r_sample)) begin
                    r_stable_cnt <= r_stable_cnt + FCNT_W'(1);
                end else begin
                    r_stable_cnt <= FCNT_W'(1);
                end
            end
            if (w_state_nxt != r_state) begin
                r_dly <= '0;
            end else if ((r_state == S_CLK_WAIT) || (r_state == S_SRST_WAIT)) begin
                r_dly <= r_dly + DLY_W'(1);
            end
            r_latch   <= w_latch_nxt;
            r_sticky  <= w_sticky_nxt;
            r_valid   <= w_valid_nxt;
            r_err     <= w_err_nxt;
            r_clk_enb <= w_clk_enb_nxt;
            r_srst_n  <= w_srst_n_nxt;
        end
    end

    assign strap_latch  = r_latch;
    assign strap_sticky = r_sticky;
    assign strap_valid  = r_valid;
    assign strap_err    = r_err;
    assign clk_enb      = r_clk_enb;
    assign s_reset_n    = r_srst_n;

endmodule
